ip_instr_issuer: RTL and testbench

- Host-side initiator for the image processor core: accepts instruction words (cellA, cellB, x, y, opcode) from a host over a valid/ready interface.
- Buffers them in a small FIFO and drives them to the core one at a time, holding each word stable for the core's fixed latency.
- Captures the core's pixel-matrix result and returns it to the host with a sequence tag.
- Replaces the hand-timed "drive IW, wait N negedges" stimulus pattern with a synthesizable, back-pressured sequencer.

---
 rtl/ip_instr_issuer.sv | 225 ++++++++++++++++++++++
 tb/tb_ip_instr_issuer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_instr_issuer.sv
`default_nettype none
// ============================================================================
// Module   : ip_instr_issuer
// Purpose  : Host-side initiator for the image processor core. Buffers host
//            instruction words in a small FIFO, drives them to the core one
//            at a time, holds each word for the core latency, then captures
//            the pixel-matrix result and hands it back with a sequence tag.
// Revision : 1.0 - initial release
// ============================================================================
module ip_instr_issuer #(
    parameter int IW_W     = 240,
    parameter int RES_W    = 96,
    parameter int DEPTH    = 4,
    parameter int CORE_LAT = 2,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    // host instruction channel
    input  logic [IW_W-1:0]  host_iw,
    input  logic             host_valid,
    output logic             host_ready,
    // core side
    output logic [IW_W-1:0]  core_iw,
    input  logic [RES_W-1:0] core_result,
    // host result channel
    output logic [RES_W-1:0] res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_valid,
    input  logic             res_ready,
    // status
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // FIFO address width; pointers carry one extra wrap bit.
    localparam int c_aw = $clog2(DEPTH);
    // Latency counter must hold CORE_LAT-1; sized so CORE_LAT=1 still works.
    localparam int c_cw = $clog2(CORE_LAT + 1);

    localparam logic [c_aw:0]    c_ptr_one  = {{c_aw{1'b0}}, 1'b1};
    localparam logic [c_cw-1:0]  c_lat_one  = {{(c_cw-1){1'b0}}, 1'b1};
    localparam logic [c_cw-1:0]  c_lat_load = c_cw'(CORE_LAT - 1);
    localparam logic [TAG_W-1:0] c_tag_one  = {{(TAG_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Sequencer states
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // waiting for a queued instruction
        ST_ISSUE = 2'd1,   // core_iw just changed; arm the latency counter
        ST_WAIT  = 2'd2,   // counting down the core latency
        ST_RESP  = 2'd3    // result presented to host, waiting for res_ready
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Storage and control signals
    // ------------------------------------------------------------------------
    logic [IW_W-1:0]  r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    logic [c_cw-1:0]  r_lat_cnt;
    logic             w_lat_load;
    logic             w_capture;
    logic             w_release;

    logic [IW_W-1:0]  r_core_iw;
    logic [RES_W-1:0] r_res_data;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_valid;
    logic [TAG_W-1:0] r_tag_cnt;

    // ------------------------------------------------------------------------
    // FIFO status: wrap bit distinguishes full from empty when the
    // address bits coincide.
    // ------------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

    // A write is taken only while not full, so a write that collides with a
    // pop on a full FIFO is refused rather than overwriting the head.
    assign w_push  = host_valid && !w_full;

    // FIFO data array: written on an accepted host beat, no reset needed
    // because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= host_iw;
        end
    end

    // FIFO pointers advance on push/pop; reset discards any queued entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes. Pops only look at the registered
    // empty flag, so a same-cycle write never falls through to the core.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_lat_load  = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_lat_load  = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    w_release = 1'b1;
                    // Chain straight into the next instruction when one is
                    // queued, avoiding an IDLE bubble.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latency counter: armed in ISSUE, counts down while waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat_cnt <= '0;
        end else if (w_lat_load) begin
            r_lat_cnt <= c_lat_load;
        end else if ((r_state == ST_WAIT) && (r_lat_cnt != '0)) begin
            r_lat_cnt <= r_lat_cnt - c_lat_one;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // Core instruction word changes only on a pop and is otherwise held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_core_iw <= '0;
        end else if (w_pop) begin
            r_core_iw <= r_mem[r_rd_ptr[c_aw-1:0]];
        end
    end

    // Result capture with tag, held until the host takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_data  <= '0;
            r_res_tag   <= '0;
            r_res_valid <= 1'b0;
            r_tag_cnt   <= '0;
        end else if (w_capture) begin
            r_res_data  <= core_result;
            r_res_tag   <= r_tag_cnt;
            r_res_valid <= 1'b1;
            r_tag_cnt   <= r_tag_cnt + c_tag_one;
        end else if (w_release) begin
            r_res_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign host_ready = !w_full;
    assign core_iw    = r_core_iw;
    assign res_data   = r_res_data;
    assign res_tag    = r_res_tag;
    assign res_valid  = r_res_valid;
    assign busy       = !w_empty || (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ip_instr_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_instr_issuer
// Purpose  : Directed self-checking bench for ip_instr_issuer with a small
//            two-stage pipelined core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_instr_issuer;

    localparam int IW_W     = 240;
    localparam int RES_W    = 96;
    localparam int DEPTH    = 4;
    localparam int CORE_LAT = 2;
    localparam int TAG_W    = 4;

    localparam logic [31:0] OP_ADD    = 32'd0;
    localparam logic [31:0] OP_MUL    = 32'd1;
    localparam logic [31:0] OP_CREATE = 32'd2;
    localparam logic [31:0] OP_PRINT  = 32'd3;

    logic             clk;
    logic             reset;
    logic [IW_W-1:0]  host_iw;
    logic             host_valid;
    logic             host_ready;
    logic [IW_W-1:0]  core_iw;
    logic [RES_W-1:0] core_result;
    logic [RES_W-1:0] res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_valid;
    logic             res_ready;
    logic             busy;

    int tests = 0;
    int fails = 0;

    ip_instr_issuer #(
        .IW_W     (IW_W),
        .RES_W    (RES_W),
        .DEPTH    (DEPTH),
        .CORE_LAT (CORE_LAT),
        .TAG_W    (TAG_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host_iw     (host_iw),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .core_iw     (core_iw),
        .core_result (core_result),
        .res_data    (res_data),
        .res_tag     (res_tag),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: cellA[239:144] cellB[143:48] x[47:40] y[39:32] op[31:0].
    // ADD/MUL per 24-bit pixel, CREATE returns cellA, PRINT echoes cellB.
    function automatic logic [95:0] core_f(input logic [239:0] iw);
        logic [95:0] a;
        logic [95:0] b;
        logic [95:0] r;
        logic [23:0] pa;
        logic [23:0] pb;
        logic [23:0] pr;
        a = iw[239:144];
        b = iw[143:48];
        r = '0;
        for (int k = 0; k < 4; k++) begin
            pa = a[k*24 +: 24];
            pb = b[k*24 +: 24];
            case (iw[31:0])
                OP_ADD:    pr = pa + pb;
                OP_MUL:    pr = pa * pb;
                OP_CREATE: pr = pa;
                OP_PRINT:  pr = pb;
                default:   pr = '0;
            endcase
            r[k*24 +: 24] = pr;
        end
        return r;
    endfunction

    // Result is valid only CORE_LAT edges after core_iw changes.
    logic [RES_W-1:0] r_p1;
    logic [RES_W-1:0] r_p2;
    always @(posedge clk) begin
        r_p1 <= core_f(core_iw);
        r_p2 <= r_p1;
    end
    assign core_result = r_p2;

    function automatic logic [IW_W-1:0] mk(input logic [31:0] op,
                                           input logic [95:0] a,
                                           input logic [95:0] b);
        return {a, b, 8'h11, 8'h22, op};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [IW_W-1:0] iw);
        int n;
        n = 0;
        host_iw    = iw;
        host_valid = 1'b1;
        while (host_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("push_timeout", {255'd0, host_ready}, 256'd1);
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    // Called at a negedge; accepts one result and checks it.
    task automatic pop_result(input string tag, input logic [RES_W-1:0] exp_d,
                              input logic [TAG_W-1:0] exp_t);
        int n;
        n = 0;
        res_ready = 1'b1;
        while (res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {255'd0, res_valid}, 256'd1);
        check({tag, "_data"},  {160'd0, res_data}, {160'd0, exp_d});
        check({tag, "_tag"},   {252'd0, res_tag},  {252'd0, exp_t});
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    logic [IW_W-1:0]  w_iw;
    logic [IW_W-1:0]  fill_iw [6];
    logic [RES_W-1:0] fill_a  [6];

    initial begin
        reset      = 1'b1;
        host_iw    = '0;
        host_valid = 1'b0;
        res_ready  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ---- reset state ----
        check("rst_core_iw",   {16'd0, core_iw},   256'd0);
        check("rst_res_data",  {160'd0, res_data}, 256'd0);
        check("rst_res_tag",   {252'd0, res_tag},  256'd0);
        check("rst_res_valid", {255'd0, res_valid}, 256'd0);
        check("rst_busy",      {255'd0, busy},      256'd0);
        check("rst_host_ready", {255'd0, host_ready}, 256'd1);

        // ---- single op, exact latency ----
        w_iw       = mk(OP_ADD, {4{24'h000001}}, {4{24'h000001}});
        res_ready  = 1'b1;
        host_iw    = w_iw;
        host_valid = 1'b1;
        @(negedge clk);                       // edge N
        host_valid = 1'b0;
        check("single_busy_n", {255'd0, busy}, 256'd1);
        @(negedge clk);                       // N+1
        check("single_core_iw", {16'd0, core_iw}, {16'd0, w_iw});
        check("single_valid_n1", {255'd0, res_valid}, 256'd0);
        @(negedge clk);                       // N+2
        @(negedge clk);                       // N+3
        check("single_valid_n3", {255'd0, res_valid}, 256'd0);
        @(negedge clk);                       // N+4
        check("single_valid_n4", {255'd0, res_valid}, 256'd1);
        check("single_data", {160'd0, res_data}, {160'd0, {4{24'h000002}}});
        check("single_tag",  {252'd0, res_tag},  256'd0);
        check("single_busy_n4", {255'd0, busy}, 256'd1);
        @(negedge clk);                       // N+5, result accepted
        check("single_valid_n5", {255'd0, res_valid}, 256'd0);
        check("single_busy_n5",  {255'd0, busy}, 256'd0);
        res_ready = 1'b0;

        // ---- fill / back-pressure / stall ----
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fill_a[i]  = {4{24'(24'h100000 + i)}};
            fill_iw[i] = mk(OP_CREATE, fill_a[i], '0);
        end
        for (int i = 0; i < 5; i++) push(fill_iw[i]);
        check("fill_full", {255'd0, host_ready}, 256'd0);
        host_iw    = fill_iw[5];
        host_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0 || c == 9) begin
                check("stall_valid", {255'd0, res_valid}, 256'd1);
                check("stall_data",  {160'd0, res_data}, {160'd0, fill_a[0]});
                check("stall_tag",   {252'd0, res_tag},  256'd0);
                check("stall_core_iw", {16'd0, core_iw}, {16'd0, fill_iw[0]});
                check("stall_ready", {255'd0, host_ready}, 256'd0);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);                       // result 0 accepted, pop
        res_ready = 1'b0;
        check("fill_pop_ready", {255'd0, host_ready}, 256'd1);
        @(negedge clk);                       // 6th write taken
        host_valid = 1'b0;
        for (int i = 1; i < 6; i++) pop_result("fill", fill_a[i], 4'(i));
        @(negedge clk);
        check("fill_idle_busy", {255'd0, busy}, 256'd0);

        // ---- reset mid-WAIT with two entries queued ----
        do_reset();
        push(mk(OP_CREATE, {4{24'hAAAAAA}}, '0));
        push(mk(OP_CREATE, {4{24'hBBBBBB}}, '0));
        push(mk(OP_CREATE, {4{24'hCCCCCC}}, '0));
        check("rwait_busy_pre", {255'd0, busy}, 256'd1);
        reset = 1'b1;
        #1;
        check("rwait_valid",   {255'd0, res_valid}, 256'd0);
        check("rwait_ready",   {255'd0, host_ready}, 256'd1);
        check("rwait_busy",    {255'd0, busy}, 256'd0);
        check("rwait_core_iw", {16'd0, core_iw}, 256'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        push(mk(OP_CREATE, {4{24'hDDDDDD}}, '0));
        pop_result("rwait_new", {4{24'hDDDDDD}}, 4'd0);

        // ---- opcode sweep with colours ----
        push(mk(OP_ADD, {24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF},
                {4{24'h000001}}));
        pop_result("op_add", {24'h000000, 24'hFF0001, 24'h00FF01, 24'h000100}, 4'd1);
        push(mk(OP_MUL, {24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h0000FF},
                {4{24'h000002}}));
        pop_result("op_mul", {24'h000000, 24'hFFFFFE, 24'hFE0000, 24'h0001FE}, 4'd2);
        push(mk(OP_CREATE, {24'h00FF00, 24'h0000FF, 24'h000000, 24'hFFFFFF}, '0));
        pop_result("op_create", {24'h00FF00, 24'h0000FF, 24'h000000, 24'hFFFFFF}, 4'd3);
        push(mk(OP_PRINT, {4{24'hFF0000}},
                {24'h123456, 24'h789ABC, 24'hDEF012, 24'h345678}));
        pop_result("op_print", {24'h123456, 24'h789ABC, 24'hDEF012, 24'h345678}, 4'd4);

        // ---- reset mid-RESP drops res_valid asynchronously ----
        push(mk(OP_CREATE, {4{24'hEEEEEE}}, '0));
        for (int c = 0; c < 20 && res_valid !== 1'b1; c++) @(negedge clk);
        check("rresp_valid_pre", {255'd0, res_valid}, 256'd1);
        reset = 1'b1;
        #1;
        check("rresp_valid", {255'd0, res_valid}, 256'd0);
        check("rresp_data",  {160'd0, res_data}, 256'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ---- tag wrap over 17 instructions ----
        for (int i = 0; i < 17; i++) begin
            push(mk(OP_CREATE, {4{24'(i + 1)}}, '0));
            pop_result("wrap", {4{24'(i + 1)}}, 4'(i % 16));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
